frame_buf_switch: RTL and testbench

//  Triple-buffer manager between the DVP capture path (ddr3_write) and the display path (ddr3_read -> vga_ctrl).

---
 rtl/frame_buf_switch.sv | 134 +++++++++++++
 tb/tb_frame_buf_switch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_switch.sv
// Triple-buffer manager between the DVP writer and the VGA reader.
// Hands each master a DDR3 base address and a go pulse at every frame start.
module frame_buf_switch #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BUFFER0    = 32'h30880000,
  parameter logic [ADDR_WIDTH-1:0] LENGTH     = 32'h0005DC00
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  enable,
  input  logic                  dvp_frame_start,
  input  logic                  dvp_done,
  input  logic                  vga_frame_start,
  input  logic                  vga_done,
  output logic                  dvp_go,
  output logic [ADDR_WIDTH-1:0] dvp_address,
  output logic                  vga_go,
  output logic [ADDR_WIDTH-1:0] vga_address,
  output logic                  vga_valid,
  output logic [15:0]           frame_cnt,
  output logic                  wr_overrun,
  output logic                  rd_overrun
);

  logic [1:0] w_idx, l_idx, r_idx;
  logic       fresh, wr_busy, rd_busy;
  logic       dvp_done_q, vga_done_q;

  logic       dvp_done_rise, vga_done_rise, rd_ok, commit;
  logic [1:0] w_n, l_n, r_n;
  logic       fresh_n, wr_busy_n, rd_busy_n, valid_n, wov_n, rov_n, dgo_n, vgo_n;
  logic [15:0] cnt_n;
  logic [ADDR_WIDTH-1:0] daddr_n, vaddr_n;

  function automatic logic [ADDR_WIDTH-1:0] buf_addr(input logic [1:0] k);
    case (k)
      2'd1:    return BUFFER0 + LENGTH;
      2'd2:    return BUFFER0 + (LENGTH << 1);
      default: return BUFFER0;
    endcase
  endfunction

  assign dvp_done_rise = dvp_done & ~dvp_done_q;
  assign vga_done_rise = vga_done & ~vga_done_q;
  assign rd_ok         = vga_frame_start & enable & vga_valid;
  assign commit        = dvp_done_rise & wr_busy;

  always_comb begin
    w_n       = w_idx;
    l_n       = l_idx;
    r_n       = r_idx;
    fresh_n   = fresh;
    wr_busy_n = wr_busy;
    rd_busy_n = rd_busy;
    valid_n   = vga_valid;
    cnt_n     = frame_cnt;
    wov_n     = wr_overrun;
    rov_n     = rd_overrun;
    dgo_n     = 1'b0;
    vgo_n     = 1'b0;
    daddr_n   = dvp_address;
    vaddr_n   = vga_address;

    if (rd_ok && fresh) begin
      r_n     = l_idx;
      fresh_n = 1'b0;
    end

    // Indices are a permutation of {0,1,2}, so the free one is 3 minus the other two.
    if (commit) begin
      l_n       = w_idx;
      w_n       = 2'd3 - r_n - w_idx;
      fresh_n   = 1'b1;
      valid_n   = 1'b1;
      cnt_n     = frame_cnt + 16'd1;
      wr_busy_n = 1'b0;
    end

    if (dvp_frame_start && enable) begin
      if (wr_busy && !commit) wov_n = 1'b1;
      dgo_n     = 1'b1;
      daddr_n   = buf_addr(w_n);
      wr_busy_n = 1'b1;
    end

    if (vga_done_rise) rd_busy_n = 1'b0;

    if (rd_ok) begin
      if (rd_busy_n) rov_n = 1'b1;
      vgo_n     = 1'b1;
      vaddr_n   = buf_addr(r_n);
      rd_busy_n = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      w_idx       <= 2'd0;
      l_idx       <= 2'd1;
      r_idx       <= 2'd2;
      fresh       <= 1'b0;
      wr_busy     <= 1'b0;
      rd_busy     <= 1'b0;
      dvp_done_q  <= 1'b0;
      vga_done_q  <= 1'b0;
      dvp_go      <= 1'b0;
      vga_go      <= 1'b0;
      dvp_address <= BUFFER0;
      vga_address <= BUFFER0 + (LENGTH << 1);
      vga_valid   <= 1'b0;
      frame_cnt   <= '0;
      wr_overrun  <= 1'b0;
      rd_overrun  <= 1'b0;
    end else begin
      w_idx       <= w_n;
      l_idx       <= l_n;
      r_idx       <= r_n;
      fresh       <= fresh_n;
      wr_busy     <= wr_busy_n;
      rd_busy     <= rd_busy_n;
      dvp_done_q  <= dvp_done;
      vga_done_q  <= vga_done;
      dvp_go      <= dgo_n;
      vga_go      <= vgo_n;
      dvp_address <= daddr_n;
      vga_address <= vaddr_n;
      vga_valid   <= valid_n;
      frame_cnt   <= cnt_n;
      wr_overrun  <= wov_n;
      rd_overrun  <= rov_n;
    end
  end

endmodule

// File: tb/tb_frame_buf_switch.sv
// Bench for frame_buf_switch: directed scenarios plus random traffic against a buffer-role model.
module tb_frame_buf_switch;

  localparam logic [31:0] B0  = 32'h30880000;
  localparam logic [31:0] LEN = 32'h0005DC00;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic enable = 1'b0;
  logic dvp_frame_start = 1'b0, dvp_done = 1'b0, vga_frame_start = 1'b0, vga_done = 1'b0;
  logic        dvp_go, vga_go, vga_valid, wr_overrun, rd_overrun;
  logic [31:0] dvp_address, vga_address;
  logic [15:0] frame_cnt;

  always #5 sys_clk = ~sys_clk;

  frame_buf_switch #(.ADDR_WIDTH(32), .BUFFER0(B0), .LENGTH(LEN)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
    .dvp_frame_start(dvp_frame_start), .dvp_done(dvp_done),
    .vga_frame_start(vga_frame_start), .vga_done(vga_done),
    .dvp_go(dvp_go), .dvp_address(dvp_address),
    .vga_go(vga_go), .vga_address(vga_address),
    .vga_valid(vga_valid), .frame_cnt(frame_cnt),
    .wr_overrun(wr_overrun), .rd_overrun(rd_overrun)
  );

  int checks = 0;
  int failures = 0;

  // Model: which buffer the writer fills, which holds the newest frame, which is on screen.
  int          m_w, m_l, m_r;
  bit          m_fresh, m_wbusy, m_rbusy, m_valid, m_dq, m_vq, m_dgo, m_vgo, m_wov, m_rov;
  logic [31:0] m_daddr, m_vaddr;
  logic [15:0] m_cnt;

  function automatic logic [31:0] base(input int k);
    return B0 + LEN * 32'(k);
  endfunction

  task automatic model_reset();
    m_w = 0; m_l = 1; m_r = 2;
    m_fresh = 0; m_wbusy = 0; m_rbusy = 0; m_valid = 0; m_dq = 0; m_vq = 0;
    m_dgo = 0; m_vgo = 0; m_wov = 0; m_rov = 0;
    m_daddr = base(0); m_vaddr = base(2); m_cnt = '0;
  endtask

  task automatic model_clock();
    bit d_rise, v_rise, rd_ok;
    if (!sys_rst_n) begin
      model_reset();
      return;
    end
    d_rise = dvp_done && !m_dq;
    v_rise = vga_done && !m_vq;
    m_dq = dvp_done; m_vq = vga_done;
    m_dgo = 0; m_vgo = 0;
    rd_ok = vga_frame_start && enable && m_valid;
    if (rd_ok && m_fresh) begin
      m_r = m_l;
      m_fresh = 0;
    end
    if (d_rise && m_wbusy) begin
      m_l = m_w;
      for (int k = 0; k < 3; k++)
        if (k != m_r && k != m_l) m_w = k;
      m_fresh = 1; m_valid = 1; m_cnt = m_cnt + 16'd1; m_wbusy = 0;
    end
    if (dvp_frame_start && enable) begin
      if (m_wbusy) m_wov = 1;
      m_dgo = 1; m_daddr = base(m_w); m_wbusy = 1;
    end
    if (v_rise) m_rbusy = 0;
    if (rd_ok) begin
      if (m_rbusy) m_rov = 1;
      m_vgo = 1; m_vaddr = base(m_r); m_rbusy = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit ds, input bit dd, input bit vs, input bit vd);
    dvp_frame_start = ds; dvp_done = dd; vga_frame_start = vs; vga_done = vd;
    @(posedge sys_clk);
    model_clock();
    #1;
    chk("dvp_go", 32'(dvp_go), 32'(m_dgo));
    chk("dvp_address", dvp_address, m_daddr);
    chk("vga_go", 32'(vga_go), 32'(m_vgo));
    chk("vga_address", vga_address, m_vaddr);
    chk("vga_valid", 32'(vga_valid), 32'(m_valid));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("wr_overrun", 32'(wr_overrun), 32'(m_wov));
    chk("rd_overrun", 32'(rd_overrun), 32'(m_rov));
    if (sys_rst_n && m_dgo) chk("dvp_vs_read_differ", 32'(dvp_address != base(m_r)), 32'd1);
    if (sys_rst_n && m_vgo && m_wbusy) chk("vga_vs_write_differ", 32'(vga_address != base(m_w)), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dvp_go"}, 32'(dvp_go), 32'd0);
    chk({tag, "_vga_go"}, 32'(vga_go), 32'd0);
    chk({tag, "_dvp_address"}, dvp_address, 32'h30880000);
    chk({tag, "_vga_address"}, vga_address, 32'h3093B800);
    chk({tag, "_vga_valid"}, 32'(vga_valid), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_overruns"}, {30'd0, wr_overrun, rd_overrun}, 32'd0);
  endtask

  logic [31:0] first_vaddr;
  bit dd_lvl, vd_lvl;

  initial begin
    model_reset();
    sys_rst_n = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_reset_outputs("reset");
    sys_rst_n = 1'b1;
    enable = 1'b1;

    // T1: first write go, read start ignored while nothing is committed
    step(1, 0, 0, 0);
    chk("t1_dvp_go", 32'(dvp_go), 32'd1);
    chk("t1_dvp_address", dvp_address, 32'h30880000);
    step(0, 0, 1, 0);
    chk("t1_no_vga_go", 32'(vga_go), 32'd0);

    // T2: commit, read picks buffer 0, next write goes to buffer 1
    step(0, 1, 0, 0);
    chk("t2_valid", 32'(vga_valid), 32'd1);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd1);
    step(0, 1, 1, 0);
    chk("t2_vga_go", 32'(vga_go), 32'd1);
    chk("t2_vga_address", vga_address, 32'h30880000);
    step(1, 0, 0, 0);
    chk("t2_dvp_address", dvp_address, 32'h308DDC00);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // T3: DVP at three times the VGA rate
    for (int c = 0; c < 360; c++)
      step(c % 12 == 0, (c % 12) inside {8, 9}, c % 36 == 5, (c % 36) inside {28, 29});
    chk("t3_wr_overrun", 32'(wr_overrun), 32'd0);
    chk("t3_rd_overrun", 32'(rd_overrun), 32'd0);

    // T4: VGA only; second and third reads repeat the buffer of the first
    step(0, 0, 1, 0);
    first_vaddr = m_vaddr;
    for (int f = 0; f < 2; f++) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      chk("t4_vga_go", 32'(vga_go), 32'd1);
      chk("t4_repeat_address", vga_address, first_vaddr);
      chk("t4_valid", 32'(vga_valid), 32'd1);
    end
    step(0, 0, 0, 1);

    // T5: commit and read start on the same edge; read takes the previous newest frame
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    first_vaddr = base(m_l);
    step(0, 1, 1, 0);
    chk("t5_vga_go", 32'(vga_go), 32'd1);
    chk("t5_old_latest", vga_address, first_vaddr);
    step(0, 0, 0, 1);

    // T6: two starts without done, then reset
    step(1, 0, 0, 0);
    first_vaddr = dvp_address;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t6_wr_overrun", 32'(wr_overrun), 32'd1);
    chk("t6_same_address", dvp_address, m_daddr);
    chk("t6_cnt_held", 32'(frame_cnt), 32'(m_cnt));
    sys_rst_n = 1'b0;
    step(0, 0, 0, 0);
    check_reset_outputs("t6_reset");
    sys_rst_n = 1'b1;

    // Random traffic, including enable toggles, spurious dones and resets
    dd_lvl = 0; vd_lvl = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) dd_lvl = !dd_lvl;
      if ($urandom_range(0, 5) == 0) vd_lvl = !vd_lvl;
      enable = ($urandom_range(0, 9) != 0);
      sys_rst_n = ($urandom_range(0, 499) != 0);
      step($urandom_range(0, 9) == 0, dd_lvl, $urandom_range(0, 11) == 0, vd_lvl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
